// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: packet-granular round-robin sharing of one UART TX path
// among N byte-stream requesters. Ports: clk, reset (sync, active-low),
// req_valid/req_data/req_last/req_ready per requester, tx_full from the
// uart FIFO, wr_uart/w_data to the FIFO, grant_id and busy status.
// Optional macro UART_ARB_HDR_EN prefixes each packet with 8'hA0|grant_id.
module uart_tx_arbiter #(
    parameter int N    = 4,
    parameter int ID_W = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N-1:0]      req_valid,
    input  logic [8*N-1:0]    req_data,
    input  logic [N-1:0]      req_last,
    output logic [N-1:0]      req_ready,
    input  logic              tx_full,
    output logic              wr_uart,
    output logic [7:0]        w_data,
    output logic [ID_W-1:0]   grant_id,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1
`ifdef UART_ARB_HDR_EN
        ,
        HDR  = 2'd2
`endif
    } state_t;

    state_t          state, state_nx;
    logic [ID_W-1:0] last_grant;
    logic [ID_W-1:0] winner;
    logic            found;
    logic            g_valid;
    logic            g_last;
    logic [7:0]      g_data;
    logic            grant_en;
    logic            done;

    // Round-robin search: indices above last_grant first, then wrap to 0.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        for (int i = 0; i < N; i++) begin
            if (!found && req_valid[i] && i > int'(last_grant)) begin
                found  = 1'b1;
                winner = ID_W'(i);
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!found && req_valid[i] && i <= int'(last_grant)) begin
                found  = 1'b1;
                winner = ID_W'(i);
            end
        end
    end

    // Signals of the currently granted requester.
    always_comb begin
        g_valid = 1'b0;
        g_last  = 1'b0;
        g_data  = '0;
        for (int i = 0; i < N; i++) begin
            if (ID_W'(i) == grant_id) begin
                g_valid = req_valid[i];
                g_last  = req_last[i];
                g_data  = req_data[8*i +: 8];
            end
        end
    end

    always_comb begin
        state_nx  = state;
        req_ready = '0;
        wr_uart   = 1'b0;
        w_data    = '0;
        grant_en  = 1'b0;
        done      = 1'b0;
        unique case (state)
            IDLE: begin
                if (found) begin
                    grant_en = 1'b1;
`ifdef UART_ARB_HDR_EN
                    state_nx = HDR;
`else
                    state_nx = XFER;
`endif
                end
            end
`ifdef UART_ARB_HDR_EN
            HDR: begin
                if (!tx_full) begin
                    wr_uart  = 1'b1;
                    w_data   = 8'hA0 | 8'(grant_id);
                    state_nx = XFER;
                end
            end
`endif
            XFER: begin
                for (int i = 0; i < N; i++) begin
                    if (ID_W'(i) == grant_id) begin
                        req_ready[i] = ~tx_full;
                    end
                end
                if (g_valid && !tx_full) begin
                    wr_uart = 1'b1;
                    w_data  = g_data;
                    if (g_last) begin
                        done     = 1'b1;
                        state_nx = IDLE;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
        // Reset is synchronous, so the state may still read XFER while
        // reset is low; keep the FIFO interface quiet during that cycle.
        if (!reset) begin
            req_ready = '0;
            wr_uart   = 1'b0;
            w_data    = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            last_grant <= ID_W'(N-1);
            grant_id   <= '0;
            busy       <= 1'b0;
        end else begin
            state <= state_nx;
            if (grant_en) begin
                grant_id <= winner;
                busy     <= 1'b1;
            end
            if (done) begin
                last_grant <= grant_id;
                busy       <= 1'b0;
            end
        end
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single UART transmit path between N independent byte-stream requesters, e.g. debug, status and Ethernet-event reporters.
- Packet-granular round-robin arbitration: once a requester is granted, it keeps the grant until its byte flagged last is accepted.
- Drives wr_uart/w_data of the uart block.
- Respects tx_full so the TX FIFO never overflows.

Parameters:
- N, 4, number of requesters (2..8).
- ID_W, 2, width of grant_id; must satisfy N <= 2**ID_W.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-low reset (0 = reset).
- req_valid  input  N  requester i has a byte on its data slice.
- req_data  input  8*N  bytes, requester i on bits [8i+7:8i].
- req_last  input  N  byte of requester i is the final byte of its packet.
- req_ready  output  N  byte of requester i accepted this cycle when valid&ready.
- tx_full  input  1  uart TX FIFO full.
- wr_uart  output  1  write strobe to uart TX FIFO.
- w_data  output  8  byte to uart TX FIFO.
- grant_id  output  ID_W  index of current/last granted requester.
- busy  output  1  a packet is in progress (state != IDLE).

Behaviour:
- Reset (reset=0 at a clk edge): state=IDLE, last_grant=N-1 (so requester 0 wins first), grant_id=0, busy=0. req_ready=0, wr_uart=0 and w_data=0 throughout reset.
- States: IDLE, HDR (feature only), XFER.
- IDLE: if any req_valid is set, select the first set bit searching from last_grant+1 upward, wrapping modulo N. Register grant_id=winner and busy=1, then go to XFER (or HDR with the feature enabled). If no req_valid is set, stay in IDLE.
  - Arbitration costs exactly 1 idle cycle between packets.
  - Outputs are idle in IDLE.
- XFER:
  - req_ready[g]=~tx_full for g=grant_id; all other req_ready bits are 0.
  - accept = req_valid[g] & ~tx_full.
  - wr_uart=accept and w_data=req_data slice g, both combinational in the same cycle (0 latency).
  - accept with req_last[g]=1: last_grant<=g, busy<=0, next state IDLE.
  - tx_full=1: no accept, hold the state; the requester must keep valid/data/last stable.
  - req_valid[g]=0 mid-packet: grant is held indefinitely (no timeout); other requesters wait.
- Single-byte packet (valid & last in the first XFER cycle) is legal: 1 FIFO write, return to IDLE.
- Requests from non-granted requesters during XFER are ignored until the next IDLE arbitration. No starvation: each requester waits at most N-1 packets.
- w_data=0 whenever wr_uart=0.
- Reset mid-packet: abort immediately and return to the reset state. Bytes already written stay in the FIFO (uart reset governs them).
- Invalid grant (N not a power of 2): the search considers only indices 0..N-1.

Optional Feature:
- Macro UART_ARB_HDR_EN.
- Defined: IDLE goes to HDR after the grant. HDR emits one header byte 8'hA0 | grant_id (zero-extended) when tx_full=0: wr_uart=1, req_ready all 0, then go to XFER. If tx_full=1, stay in HDR. Every packet on the line is thus prefixed with its source ID.
- Undefined: the HDR state and its logic are absent; IDLE goes directly to XFER; bytes are passed through unmodified.

Test Plan:
- Reset then single request: req_valid=4'b0100 with 3 bytes 11,22,33 (last on 33) -> grant_id=2; wr_uart pulses 3 times with w_data 11,22,33; busy falls the cycle after 33; req_ready[0,1,3] stay 0.
- Round-robin: all 4 requesters hold 1-byte packets AA,BB,CC,DD continuously -> write order AA,BB,CC,DD,AA; each write is separated by 1 IDLE cycle.
- Backpressure: tx_full=1 for 5 cycles mid-packet of requester 1 -> no wr_uart, req_ready[1]=0, state held; the byte is written on the first cycle tx_full=0, with no duplicate or loss.
- Packet lock: requester 0 sends 4-byte packet; requester 3 raises valid at byte 2 -> all 4 bytes of requester 0 are written before any of requester 3; next grant_id=3.
- Reset mid-packet: assert reset=0 after byte 2 of 5 -> next cycle busy=0, wr_uart=0, grant_id=0. After release, requester 0 has priority again.
- With UART_ARB_HDR_EN: requester 1 packet 55,66 -> writes A1,55,66. With tx_full=1 during HDR, the header is held until tx_full=0.
